// File: rtl/clk_div_bank_if.sv
// Configuration port of the divider bank: channel select, ratio and a
// valid/ready handshake.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / clock-enable generator with
// glitch-free retuning at period boundaries and a global phase-align input.
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                en,
    input  logic                sync,
    clk_div_bank_if.slave       cfg,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0]  pend_v;
    logic [2**CH_W-1:0]   pend_all;
    logic                 ready;

    // Selector codes beyond the last channel see a permanently empty slot,
    // so writes to them are always accepted and simply dropped.
    always_comb begin
        pend_all                 = '0;
        pend_all[CHANNELS-1:0]   = pend_v;
    end

    assign ready         = !pend_all[cfg.cfg_ch];
    assign cfg.cfg_ready = ready;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DIV_W-1:0] r_reg, r_next;
            logic [DIV_W-1:0] cnt_reg, cnt_next;
            logic [DIV_W-1:0] pend_div_reg, pend_div_next;
            logic             pend_v_reg, pend_v_next;
            logic             clk_out_reg, tick_reg;
            logic             wr;
            logic             eff_v;
            logic [DIV_W-1:0] eff_div;
            logic             wrap;
            logic [DIV_W:0]   r_plus;
            logic [DIV_W-1:0] half;

            // A write landing in an apply cycle is treated as already pending,
            // which gives the one-cycle latency on idle channels and lets a
            // same-cycle sync pick it up.
            always_comb begin
                r_next        = r_reg;
                cnt_next      = cnt_reg;
                pend_div_next = pend_div_reg;
                pend_v_next   = pend_v_reg;
                wr            = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(gi));
                eff_v         = pend_v_reg || wr;
                eff_div       = wr ? cfg.cfg_div : pend_div_reg;
                wrap          = en && (r_reg != '0) && (cnt_reg == r_reg - DIV_W'(1));

                if (wr) begin
                    pend_div_next = cfg.cfg_div;
                    pend_v_next   = 1'b1;
                end

                if (sync) begin
                    cnt_next = '0;
                    if (eff_v) begin
                        r_next      = eff_div;
                        pend_v_next = 1'b0;
                    end
                end else if (eff_v && ((r_reg == '0) || wrap)) begin
                    r_next      = eff_div;
                    cnt_next    = '0;
                    pend_v_next = 1'b0;
                end else if (en && (r_reg != '0)) begin
                    cnt_next = wrap ? '0 : cnt_reg + DIV_W'(1);
                end
            end

            // High phase length is ceil(R/2); outputs decode the next state so
            // they are flops aligned with the counter.
            assign r_plus = {1'b0, r_next} + {{DIV_W{1'b0}}, 1'b1};
            assign half   = DIV_W'(r_plus >> 1);

            always_ff @(posedge clk) begin
                if (!rst_) begin
                    r_reg        <= '0;
                    cnt_reg      <= '0;
                    pend_div_reg <= '0;
                    pend_v_reg   <= 1'b0;
                    clk_out_reg  <= 1'b0;
                    tick_reg     <= 1'b0;
                end else begin
                    r_reg        <= r_next;
                    cnt_reg      <= cnt_next;
                    pend_div_reg <= pend_div_next;
                    pend_v_reg   <= pend_v_next;
                    clk_out_reg  <= (r_next != '0) && (cnt_next < half);
                    tick_reg     <= (r_next != '0) && (cnt_next == '0);
                end
            end

            assign clk_out[gi] = clk_out_reg;
            assign tick[gi]    = tick_reg;
            assign pend_v[gi]  = pend_v_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: five channels so that an out-of-range
// channel code is representable.
module tb_clk_div_bank;
    localparam int CHANNELS = 5;
    localparam int DIV_W    = 8;
    localparam int CH_W     = 3;

    logic                clk = 1'b0;
    logic                rst_;
    logic                en;
    logic                sync;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    int n_vec = 0;
    int n_err = 0;

    clk_div_bank_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg_bus ();

    clk_div_bank #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int div);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = CH_W'(ch);
        cfg_bus.cfg_div   = DIV_W'(div);
        cyc();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    function automatic logic ec(input int r, input int k);
        return (r != 0) && ((k % r) < ((r + 1) / 2));
    endfunction

    function automatic logic et(input int r, input int k);
        return (r != 0) && ((k % r) == 0);
    endfunction

    initial begin
        logic [CHANNELS-1:0] ev_clk, ev_tick;
        rst_ = 1'b0; en = 1'b0; sync = 1'b0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0;
        cyc(); cyc();
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        rst_ = 1'b1; en = 1'b1;
        cyc();

        // ch0 R=4 from idle: visible the very next cycle
        write(0, 4);
        for (int k = 0; k < 9; k++) begin
            $display("r4 k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("r4_clk", 32'(clk_out[0]), 32'(ec(4, k)));
            check("r4_tick", 32'(tick[0]), 32'(et(4, k)));
            check("r4_others", 32'(clk_out[4:1] | tick[4:1]), 32'h0);
            if (k < 8) cyc();
        end
        cyc();  // ch0 now at cnt=1

        // Retune ch0 to 6 mid-period; a second write must stall until the wrap
        check("rt_ready0", 32'(cfg_bus.cfg_ready), 32'h1);
        check("rt_clk_c1", 32'(clk_out[0]), 32'h1);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 3'd0; cfg_bus.cfg_div = 8'd6;
        cyc();
        cfg_bus.cfg_div = 8'd2;
        check("rt_stall_c2", 32'(cfg_bus.cfg_ready), 32'h0);
        check("rt_clk_c2", 32'(clk_out[0]), 32'h0);
        cyc();
        check("rt_stall_c3", 32'(cfg_bus.cfg_ready), 32'h0);
        check("rt_clk_c3", 32'(clk_out[0]), 32'h0);
        cyc();
        cfg_bus.cfg_valid = 1'b0;
        check("rt_ready_after", 32'(cfg_bus.cfg_ready), 32'h1);
        for (int k = 0; k < 12; k++) begin
            $display("r6 k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("r6_clk", 32'(clk_out[0]), 32'(ec(6, k)));
            check("r6_tick", 32'(tick[0]), 32'(et(6, k)));
            cyc();
        end

        // ch1 odd ratio 5
        write(1, 5);
        for (int k = 0; k < 10; k++) begin
            $display("r5 k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("r5_clk", 32'(clk_out[1]), 32'(ec(5, k)));
            check("r5_tick", 32'(tick[1]), 32'(et(5, k)));
            cyc();
        end

        // ch2 R=3, then ch3 R=1
        write(2, 3);
        write(3, 1);
        for (int k = 1; k < 7; k++) begin
            $display("r3r1 k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("r3_clk", 32'(clk_out[2]), 32'(ec(3, k)));
            check("r1_clk", 32'(clk_out[3]), 32'h1);
            check("r1_tick", 32'(tick[3]), 32'h1);
            check("ch4_idle", 32'(clk_out[4] | tick[4]), 32'h0);
            cyc();
        end

        // Re-ratio ch0=4 / ch1=6, second write coincides with sync
        write(0, 4);
        sync = 1'b1;
        write(1, 6);
        sync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ev_clk  = {1'b0, ec(1, k), ec(3, k), ec(6, k), ec(4, k)};
            ev_tick = {1'b0, et(1, k), et(3, k), et(6, k), et(4, k)};
            $display("sync k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("sync_clk", 32'(clk_out), 32'(ev_clk));
            check("sync_tick", 32'(tick), 32'(ev_tick));
            if (k == 5) begin
                en = 1'b0;
                for (int f = 0; f < 3; f++) begin
                    cyc();
                    $display("frozen f=%0d clk_out=%b tick=%b", f, clk_out, tick);
                    check("freeze_clk", 32'(clk_out), 32'(ev_clk));
                    check("freeze_tick", 32'(tick), 32'(ev_tick));
                end
                en = 1'b1;
            end
            if (k < 9) cyc();
        end
        // k=9 now: ch1 cnt=3, pending write then reset
        write(1, 9);
        rst_ = 1'b0;
        cyc();
        rst_ = 1'b1;
        cfg_bus.cfg_ch = 3'd1;
        $display("reset clk_out=%b tick=%b ready=%b", clk_out, tick, cfg_bus.cfg_ready);
        check("mrst_clk", 32'(clk_out), 32'h0);
        check("mrst_tick", 32'(tick), 32'h0);
        check("mrst_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        cyc();
        check("mrst_pend_lost", 32'(clk_out | tick), 32'h0);

        // Out-of-range channel: accepted, no effect
        cfg_bus.cfg_ch = 3'd5;
        check("oor_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        write(5, 3);
        for (int k = 0; k < 4; k++) begin
            $display("oor k=%0d clk_out=%b tick=%b", k, clk_out, tick);
            check("oor_noeffect", 32'(clk_out | tick), 32'h0);
            cyc();
        end
        cfg_bus.cfg_ch = 3'd5;
        check("oor_ready_after", 32'(cfg_bus.cfg_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
